// File: rtl/seg7_scan_capture.sv
// Monitor for a multiplexed 7-segment display bus: recovers the digit shown on
// each scan position once the bus has dwelt on it for STABLE_CYCLES samples.
module seg7_scan_capture #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned INVERT_INPUT   = 1,
    parameter int unsigned SEL_ACTIVE_LOW = 1,
    parameter int unsigned STABLE_CYCLES  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     sel_in,
    output logic [4*NUM_DIGITS-1:0]   digits_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      changed,
    output logic                      sel_err
);

    localparam int unsigned DW         = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W      = 8;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] sel_n;
    logic                  sel_multi;
    logic                  sel_single;
    logic                  sel_q_multi;
    logic                  capture;
    logic [4:0]            dec;
    logic [3:0]            slot_val;
    logic                  slot_vld;
    logic                  slot_err;

    logic [6:0]            seg_q,      seg_d;
    logic [NUM_DIGITS-1:0] sel_q,      sel_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  captured_q, captured_d;
    logic [DW-1:0]         digits_q,   digits_d;
    logic [NUM_DIGITS-1:0] valid_q,    valid_d;
    logic [NUM_DIGITS-1:0] err_q,      err_d;
    logic                  changed_q,  changed_d;
    logic                  sel_err_q,  sel_err_d;

    // Segment pattern (g..a) to {legal, digit}
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h3F:   return {1'b1, 4'd0};
            7'h06:   return {1'b1, 4'd1};
            7'h5B:   return {1'b1, 4'd2};
            7'h4F:   return {1'b1, 4'd3};
            7'h66:   return {1'b1, 4'd4};
            7'h6D:   return {1'b1, 4'd5};
            7'h7D:   return {1'b1, 4'd6};
            7'h07:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h6F:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    always_comb begin
        seg_n = (INVERT_INPUT != 0)   ? ~seg_in : seg_in;
        sel_n = (SEL_ACTIVE_LOW != 0) ? ~sel_in : sel_in;
    end

    assign sel_multi   = (sel_n & (sel_n - NUM_DIGITS'(1))) != '0;
    assign sel_single  = (|sel_n) & ~sel_multi;
    assign sel_q_multi = (sel_q & (sel_q - NUM_DIGITS'(1))) != '0;
    assign dec         = seg_decode(seg_n);

    // Dwell tracking against the previous sample, then one capture per dwell
    always_comb begin
        seg_d      = seg_n;
        sel_d      = sel_n;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        err_d      = err_q;
        changed_d  = 1'b0;
        sel_err_d  = sel_q_multi;
        capture    = 1'b0;
        slot_val   = 4'd0;
        slot_vld   = 1'b0;
        slot_err   = 1'b0;

        if (!sel_single) begin
            cnt_d      = '0;
            captured_d = 1'b0;
        end else if ((seg_n != seg_q) || (sel_n != sel_q)) begin
            cnt_d      = CNT_W'(1);
            captured_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (sel_single && (cnt_d == CNT_TARGET) && !captured_d) begin
            capture    = 1'b1;
            captured_d = 1'b1;
        end

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (capture && sel_n[i]) begin
                slot_val = digits_q[4*i +: 4];
                slot_vld = 1'b0;
                slot_err = 1'b0;
                if (seg_n == 7'h00) begin
                    slot_val = 4'd0;
                end else if (dec[4]) begin
                    slot_val = dec[3:0];
                    slot_vld = 1'b1;
                end else begin
                    slot_err = 1'b1;
                end
                if ({slot_val, slot_vld, slot_err} !=
                    {digits_q[4*i +: 4], valid_q[i], err_q[i]}) begin
                    changed_d = 1'b1;
                end
                digits_d[4*i +: 4] = slot_val;
                valid_d[i]         = slot_vld;
                err_d[i]           = slot_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            digits_q   <= '0;
            valid_q    <= '0;
            err_q      <= '0;
            changed_q  <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            changed_q  <= changed_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign changed     = changed_q;
    assign sel_err     = sel_err_q;

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiving end of the multiplexed 7-segment display bus: watches the segment lines and digit-select lines driven to the score displays and recovers the decimal digit on each position.
- Used as an on-chip monitor/readback of the displayed score, and as a checker in display-path benches.
- Filters scan glitches with a stability window and reports illegal patterns per digit.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- INVERT_INPUT, 1, 1 = seg_in is active-low; it is inverted before decoding.
- SEL_ACTIVE_LOW, 1, 1 = sel_in bits are active-low (common-anode drive).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines. bit0=a, bit1=b, … bit6=g. Polarity set by INVERT_INPUT.
- sel_in  in  NUM_DIGITS  digit-select lines. Polarity set by SEL_ACTIVE_LOW.
- digits_out  out  4*NUM_DIGITS  recovered values. Digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  1 = the last capture on digit i was a legal digit 0-9.
- digit_err  out  NUM_DIGITS  1 = the last capture on digit i was an illegal pattern.
- changed  out  1  one-cycle pulse when any digit slot's value, valid or err bit changes.
- sel_err  out  1  one-cycle pulse when more than one select is active in a sample.

Behaviour:
- Reset, applied synchronously on any edge with reset=1, including mid-dwell:
  - digits_out=0, digit_valid=0, digit_err=0, changed=0, sel_err=0.
  - Internal sample register, hold counter and captured flag are all cleared.
- Input stage:
  - seg_in and sel_in are registered once.
  - Polarity is normalised to active-high (seg_n, sel_n) per the parameters.
- Sample classes:
  - NONE: sel_n==0. Counter cleared; no capture.
  - MULTI: more than one bit of sel_n set. Counter cleared, no capture, sel_err pulses on the following edge.
  - SINGLE: exactly one bit i of sel_n set. This is tracked.
- Hold counter, width 8 bits, saturating:
  - Increments while the normalised (sel_n, seg_n) pair equals the previous sample.
  - Reloads to 1 on any difference in either field. The captured flag clears at the same time.
- Capture:
  - Triggered when the counter reaches STABLE_CYCLES for a SINGLE sample and the captured flag is clear.
  - The captured flag is then set, so there is exactly one capture per dwell.
- Timing: if a pattern is first registered at edge E0 and held, the outputs update at edge E0+STABLE_CYCLES-1. From the input pins this is STABLE_CYCLES clocks. changed is asserted in the same cycle the outputs update.
- Decode of seg_n, as hex of bits g..a:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - Legal code: slot i value set to the decoded digit, valid=1, err=0.
  - 00 (blank): slot value set to 0, valid=0, err=0.
  - Any other code: value unchanged, valid=0, err=1.
- changed pulses only if the slot's {value, valid, err} differs from its prior contents. Re-capturing identical data produces no pulse.
- Only one slot can update per cycle. Other slots hold their contents indefinitely; there is no timeout.
- A digit change without a select change (same i, new seg) starts a new dwell and is captured again after STABLE_CYCLES.

Test Plan (defaults; pin values active-low):
1. Reset then idle with sel_in=4'b1111 → all outputs 0; changed and sel_err never assert.
2. sel_in=4'b1110, seg_in=7'b0100100 (digit 2), held → digits_out[3:0]=2 and digit_valid[0]=1 exactly 4 clocks after the input change. changed=1 for one cycle. Holding for 20 more clocks produces no further changed pulses.
3. Scan: digit0 carries 5 and digit1 carries 9, each for 6 clocks, alternating for 4 rounds → digits_out=16'h0095 after the first round. changed pulses exactly twice in total.
4. Glitch filter: digit0 pattern for 3 clocks, then a different pattern → no capture; outputs unchanged.
5. sel_in=4'b1100 (two digits active) for 5 clocks → sel_err pulses after the first sample; no slot changes. Then seg_in=~7'h49 (illegal code) on digit3 for 4 clocks → digit_err[3]=1, digit_valid[3]=0, digits_out[15:12] unchanged, changed pulses once.
6. Assert reset at hold count 3 during a dwell, release it, keep the same inputs → no capture until 4 full clocks after release; all outputs read 0 during and immediately after reset.
